// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: drives a ring-oscillator PUF through a challenge batch and majority-votes a key
module ro_puf_sequencer #(
  parameter int CHA_W = 4,
  parameter int RESP_W = 4,
  parameter int NUM_CHAL = 8,
  parameter int REPEAT = 3,
  parameter int SETTLE = 16,
  parameter int WINDOW = 1024,
  localparam int IW = NUM_CHAL > 1 ? $clog2(NUM_CHAL) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CHA_W-1:0]           base_cha0,
  input  logic [CHA_W-1:0]           base_cha1,
  input  logic [RESP_W-1:0]          puf_response,
  output logic                       puf_reset,
  output logic [CHA_W-1:0]           puf_cha0,
  output logic [CHA_W-1:0]           puf_cha1,
  output logic                       puf_enable,
  output logic                       busy,
  output logic                       resp_valid,
  output logic [IW-1:0]              resp_idx,
  output logic [RESP_W-1:0]          resp_data,
  output logic [NUM_CHAL*RESP_W-1:0] key_out,
  output logic                       done,
  output logic                       key_valid
);
  localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
  localparam int OW = $clog2(REPEAT + 1);
  localparam int MX = WINDOW > SETTLE ? WINDOW : SETTLE;
  localparam int CW = $clog2(MX + 3) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, SAMPLE, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;
  logic [IW-1:0] idx;
  logic [CHA_W-1:0] base0, base1;
  logic [RESP_W-1:0] sync1, sync2, vote;
  logic [OW-1:0] ones [RESP_W];
  logic fin, kill, go, cap, last_rep, last_idx;
  assign kill = abort && state != IDLE;
  assign go = start && !abort && state == IDLE;
  assign cap = state == SAMPLE && cnt == CW'(2);
  assign last_rep = rep == RW'(REPEAT - 1);
  assign last_idx = idx == IW'(NUM_CHAL - 1);
  function automatic logic [2*CHA_W-1:0] chal(input logic [CHA_W-1:0] b0, input logic [CHA_W-1:0] b1, input logic [IW-1:0] i);
    logic [CHA_W-1:0] c0, c1;
    c0 = b0 + CHA_W'(i);
    c1 = b1 + CHA_W'(i);
    return {c0, (c1 == c0) ? c0 + CHA_W'(1) : c1};
  endfunction
  // Next-state decode; the voting cycle after the final capture (fin) leads to DONE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? CLEAR : IDLE;
      CLEAR:   nxt = fin ? DONE : cnt == CW'(SETTLE - 1) ? MEASURE : CLEAR;
      MEASURE: nxt = cnt == CW'(WINDOW - 1) ? SAMPLE : MEASURE;
      SAMPLE:  nxt = cap ? CLEAR : SAMPLE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  // State and phase counter; PUF control lines decoded from the next state so they come off flops
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      puf_reset <= 1'b1;
      puf_enable <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + CW'(1);
      puf_reset <= nxt == IDLE || nxt == CLEAR;
      puf_enable <= nxt == MEASURE;
      busy <= nxt != IDLE;
    end
  // Two-flop synchronizer for the free-running PUF response
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  // Per-bit majority including the sample being captured this cycle
  always_comb begin
    vote = '0;
    for (int b = 0; b < RESP_W; b++) vote[b] = ones[b] + OW'(sync2[b]) > OW'(REPEAT / 2);
  end
  // Batch datapath: challenges, vote tallies, key packing and result pulses
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      base0 <= '0;
      base1 <= '0;
      puf_cha0 <= '0;
      puf_cha1 <= '0;
      idx <= '0;
      rep <= '0;
      fin <= 1'b0;
      resp_valid <= 1'b0;
      resp_idx <= '0;
      resp_data <= '0;
      key_out <= '0;
      done <= 1'b0;
      key_valid <= 1'b0;
      for (int b = 0; b < RESP_W; b++) ones[b] <= '0;
    end else begin
      resp_valid <= 1'b0;
      done <= 1'b0;
      fin <= 1'b0;
      if (kill) begin
        idx <= '0;
        rep <= '0;
        key_out <= '0;
        key_valid <= 1'b0;
        for (int b = 0; b < RESP_W; b++) ones[b] <= '0;
      end else if (go) begin
        base0 <= base_cha0;
        base1 <= base_cha1;
        {puf_cha0, puf_cha1} <= chal(base_cha0, base_cha1, '0);
        idx <= '0;
        rep <= '0;
        key_out <= '0;
        key_valid <= 1'b0;
        for (int b = 0; b < RESP_W; b++) ones[b] <= '0;
      end else if (cap && !last_rep) begin
        rep <= rep + RW'(1);
        for (int b = 0; b < RESP_W; b++) ones[b] <= ones[b] + OW'(sync2[b]);
      end else if (cap) begin
        resp_valid <= 1'b1;
        resp_idx <= idx;
        resp_data <= vote;
        key_out[int'(idx)*RESP_W +: RESP_W] <= vote;
        rep <= '0;
        fin <= last_idx;
        for (int b = 0; b < RESP_W; b++) ones[b] <= '0;
        if (!last_idx) begin
          idx <= idx + IW'(1);
          {puf_cha0, puf_cha1} <= chal(base0, base1, idx + IW'(1));
        end
      end else if (fin) begin
        done <= 1'b1;
        key_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: scoreboard bench with a behavioural PUF and majority-vote reference model
module tb_ro_puf_sequencer;
  localparam int N = 2, R = 3, S = 2, W = 8, L = S + W + 3;
  logic clock = 0, reset = 1, start = 0, abort = 0;
  logic [3:0] base_cha0 = 0, base_cha1 = 0, puf_response = 0;
  logic puf_reset, puf_enable, busy, resp_valid, done, key_valid;
  logic [3:0] puf_cha0, puf_cha1, resp_data;
  logic [0:0] resp_idx;
  logic [N*4-1:0] key_out;
  int errors = 0, checks = 0, cyc = 0, run_cnt = 0, done_cnt = 0;
  bit flush = 1;
  logic [3:0] runs [N*R];
  logic [3:0] run_q [$];
  logic [7:0] cha_q [$];
  int exp_idx_q [$];
  logic [3:0] exp_data_q [$];
  int done_cyc_q [$];
  logic [N*4-1:0] done_key_q [$];

  ro_puf_sequencer #(.CHA_W(4), .RESP_W(4), .NUM_CHAL(N), .REPEAT(R), .SETTLE(S), .WINDOW(W)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_cha0(base_cha0), .base_cha1(base_cha1), .puf_response(puf_response),
    .puf_reset(puf_reset), .puf_cha0(puf_cha0), .puf_cha1(puf_cha1), .puf_enable(puf_enable),
    .busy(busy), .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_data(resp_data),
    .key_out(key_out), .done(done), .key_valid(key_valid)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic clear_q();
    run_q.delete(); cha_q.delete(); exp_idx_q.delete(); exp_data_q.delete();
    done_cyc_q.delete(); done_key_q.delete();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_puf_reset"}, puf_reset, 1);
    chk({p, "_puf_enable"}, puf_enable, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_key_valid"}, key_valid, 0);
    chk({p, "_key_out"}, key_out, 0);
    chk({p, "_cha0"}, puf_cha0, 0);
    chk({p, "_cha1"}, puf_cha1, 0);
    chk({p, "_resp_data"}, resp_data, 0);
    chk({p, "_resp_idx"}, resp_idx, 0);
  endtask

  // Behavioural PUF: each run presents the next queued response from the moment enable rises
  initial begin
    bit ep;
    ep = 0;
    forever begin
      @(negedge clock);
      if (puf_enable && !ep && run_q.size() > 0) puf_response = run_q.pop_front();
      ep = puf_enable;
    end
  end

  // Monitor: compares challenges, window length, responses and completion against the scoreboard
  initial begin
    bit ep;
    int len;
    logic [7:0] c;
    ep = 0;
    len = 0;
    forever begin
      @(negedge clock);
      if (flush) begin
        ep = puf_enable;
        len = 0;
      end else begin
        if (puf_enable && !ep) begin
          run_cnt++;
          chk("cha_pending", cha_q.size() > 0, 1);
          if (cha_q.size() > 0) begin
            c = cha_q.pop_front();
            chk("puf_cha0", puf_cha0, c[7:4]);
            chk("puf_cha1", puf_cha1, c[3:0]);
          end
        end
        if (puf_enable) len++;
        if (!puf_enable && ep) begin
          chk("enable_len", len, W);
          len = 0;
        end
        ep = puf_enable;
        if (resp_valid) begin
          chk("resp_pending", exp_idx_q.size() > 0, 1);
          if (exp_idx_q.size() > 0) begin
            chk("resp_idx", resp_idx, exp_idx_q.pop_front());
            chk("resp_data", resp_data, exp_data_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_pending", done_cyc_q.size() > 0, 1);
          if (done_cyc_q.size() > 0) begin
            chk("done_cycle", cyc, done_cyc_q.pop_front());
            chk("done_key_out", key_out, done_key_q.pop_front());
            chk("done_key_valid", key_valid, 1);
          end
        end
      end
    end
  end

  // One batch: model the expected challenges and votes, launch, then finish, abort or poke start
  task automatic run_batch(input logic [3:0] b0, input logic [3:0] b1, input int abort_run, input bit poke);
    logic [N*4-1:0] key;
    logic [3:0] v;
    logic [7:0] cc;
    int t0, d0, r0, c0, c1, ones;
    key = '0;
    for (int i = 0; i < N; i++) begin
      c0 = (int'(b0) + i) % 16;
      c1 = (int'(b1) + i) % 16;
      if (c1 == c0) c1 = (c1 + 1) % 16;
      cc = {c0[3:0], c1[3:0]};
      v = '0;
      for (int b = 0; b < 4; b++) begin
        ones = 0;
        for (int k = 0; k < R; k++) ones += int'(runs[i*R+k][b]);
        v[b] = 2 * ones > R;
      end
      key[i*4 +: 4] = v;
      if ((i + 1) * R <= abort_run) begin
        exp_idx_q.push_back(i);
        exp_data_q.push_back(v);
      end
      for (int k = 0; k < R; k++) if (i * R + k <= abort_run) cha_q.push_back(cc);
    end
    for (int k = 0; k < N * R; k++) run_q.push_back(runs[k]);
    d0 = done_cnt;
    r0 = run_cnt;
    @(negedge clock);
    base_cha0 = b0;
    base_cha1 = b1;
    start = 1;
    @(posedge clock);
    #1;
    t0 = cyc;
    start = 0;
    base_cha0 = 4'($urandom);
    base_cha1 = 4'($urandom);
    if (abort_run >= N * R) begin
      done_cyc_q.push_back(t0 + 1 + N * R * L);
      done_key_q.push_back(key);
    end
    chk("start_key_valid", key_valid, 0);
    chk("start_busy", busy, 1);
    chk("start_puf_reset", puf_reset, 1);
    if (poke) begin
      repeat (20) @(negedge clock);
      start = 1;
      base_cha0 = 4'($urandom);
      base_cha1 = 4'($urandom);
      @(negedge clock);
      start = 0;
    end
    if (abort_run < N * R) begin
      for (int k = 0; k < 400 && run_cnt < r0 + abort_run + 1; k++) @(negedge clock);
      chk("abort_reached", run_cnt - r0, abort_run + 1);
      chk("pre_abort_key", key_out[3:0], key[3:0]);
      @(posedge clock);
      #2;
      abort = 1;
      flush = 1;
      @(posedge clock);
      #1;
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_enable", puf_enable, 0);
      chk("abort_puf_reset", puf_reset, 1);
      chk("abort_key_out", key_out, 0);
      chk("abort_key_valid", key_valid, 0);
      clear_q();
      @(posedge clock);
      #1;
      flush = 0;
      repeat (100) @(negedge clock);
      chk("abort_no_done", done_cnt, d0);
      chk("abort_idle_busy", busy, 0);
    end else begin
      for (int k = 0; k < 400 && done_cnt == d0; k++) @(negedge clock);
      chk("done_count", done_cnt, d0 + 1);
      repeat (3) @(negedge clock);
      chk("resp_drained", exp_idx_q.size(), 0);
      chk("cha_drained", cha_q.size(), 0);
      chk("idle_busy", busy, 0);
      chk("idle_key_valid", key_valid, 1);
      chk("idle_key_out", key_out, key);
    end
  endtask

  initial begin
    #12;
    chk_reset("por");
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    flush = 0;
    for (int k = 0; k < N * R; k++) runs[k] = 4'hA;
    run_batch(4'h3, 4'h5, 1000, 0);
    runs[0] = 4'hF; runs[1] = 4'h0; runs[2] = 4'h5;
    runs[3] = 4'hF; runs[4] = 4'hF; runs[5] = 4'h0;
    run_batch(4'($urandom), 4'($urandom), 1000, 0);
    for (int k = 0; k < N * R; k++) runs[k] = 4'($urandom);
    run_batch(4'hF, 4'hF, 1000, 1);
    for (int k = 0; k < N * R; k++) runs[k] = 4'hA;
    run_batch(4'h2, 4'h9, 4, 0);
    flush = 1;
    clear_q();
    @(negedge clock);
    base_cha0 = 4'h1;
    base_cha1 = 4'h2;
    start = 1;
    @(negedge clock);
    start = 0;
    for (int k = 0; k < 100 && !puf_enable; k++) @(negedge clock);
    chk("rst_in_measure", puf_enable, 1);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1;
    #1;
    chk_reset("async");
    @(negedge clock);
    reset = 0;
    clear_q();
    @(posedge clock);
    #1;
    flush = 0;
    for (int k = 0; k < N * R; k++) runs[k] = 4'($urandom);
    run_batch(4'($urandom), 4'($urandom), 1000, 0);
    repeat (4) begin
      for (int k = 0; k < N * R; k++) runs[k] = 4'($urandom);
      run_batch(4'($urandom), 4'($urandom), 1000, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
